// File: rtl/vram_cmd_pkg.sv
// Purpose : shared definitions for the host-write FIFO to VRAM command decoder.
//           Opcode encodings, command-word field positions, the FSM state
//           enum and a helper that tells which states may pop the FIFO.
// Ports   : none (package).
package vram_cmd_pkg;

    localparam logic [1:0] OP_SET_ADDR = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_FILL     = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_WR_DATA,
        ST_WR_ISSUE,
        ST_FILL_VAL,
        ST_FILL_ISSUE
    } state_e;

    // States that consume a FIFO word whenever one is available.
    function automatic logic is_pop_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_ADDR_LO) ||
               (s == ST_WR_DATA) || (s == ST_FILL_VAL);
    endfunction

endpackage

// File: rtl/fifo_vram_writer_if.sv
// Purpose : bundles the FIFO read port (first-word-fall-through) and the
//           single-word VRAM write request port used by fifo_vram_writer.
// Signals : rd_data/rd_empty/rd_en   FIFO head word, empty flag, pop strobe
//           vram_req/addr/wdata/ack  write request held until one-cycle ack
// Modports: master = the command decoder, slave = FIFO + arbiter side.
interface fifo_vram_writer_if #(
    parameter int ADDR_W = 17
);
    logic [15:0]       rd_data;
    logic              rd_empty;
    logic              rd_en;
    logic              vram_req;
    logic [ADDR_W-1:0] vram_addr;
    logic [15:0]       vram_wdata;
    logic              vram_ack;

    modport master (
        input  rd_data, rd_empty, vram_ack,
        output rd_en, vram_req, vram_addr, vram_wdata
    );

    modport slave (
        output rd_data, rd_empty, vram_ack,
        input  rd_en, vram_req, vram_addr, vram_wdata
    );
endinterface

// File: rtl/fifo_vram_writer.sv
// Purpose : drains 16-bit command/data words from the host-write FIFO and
//           issues single-word VRAM writes. Commands: SET_ADDR (two words),
//           WRITE (N data words follow), FILL (one value written N times);
//           the reserved opcode is discarded with a one-cycle cmd_err pulse.
// Ports   : clk      read-side clock (FIFO read clock)
//           rst_n    synchronous active-low reset
//           bus      fifo_vram_writer_if.master (FIFO read + VRAM write port)
//           busy     high whenever the FSM is not idle
//           cmd_err  one-cycle pulse after a reserved opcode is popped
module fifo_vram_writer
    import vram_cmd_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fifo_vram_writer_if.master         bus,
    output logic                       busy,
    output logic                       cmd_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              req_q,   req_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              err_q,   err_d;
    logic              pop;
    logic [1:0]        opc;

    assign opc = bus.rd_data[OPC_HI:OPC_LO];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    unique case (opc)
                        OP_SET_ADDR: begin
                            addr_d[ADDR_W-1:16] = bus.rd_data[ADDR_W-17:0];
                            state_d = ST_ADDR_LO;
                        end
                        OP_WRITE: begin
                            cnt_d   = bus.rd_data[CNT_W-1:0];
                            state_d = ST_WR_DATA;
                        end
                        OP_FILL: begin
                            cnt_d   = bus.rd_data[CNT_W-1:0];
                            state_d = ST_FILL_VAL;
                        end
                        OP_RSVD: begin
                            err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ADDR_LO: begin
                if (pop) begin
                    addr_d[15:0] = bus.rd_data;
                    state_d      = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (pop) begin
                    wdata_d = bus.rd_data;
                    req_d   = 1'b1;
                    state_d = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                if (bus.vram_ack) begin
                    req_d  = 1'b0;
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_FILL_VAL: begin
                if (pop) begin
                    wdata_d = bus.rd_data;
                    req_d   = 1'b1;
                    state_d = ST_FILL_ISSUE;
                end
            end
            ST_FILL_ISSUE: begin
                // req stays asserted between acks so a tied-high ack
                // retires one word per cycle.
                if (bus.vram_ack) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        pop            = is_pop_state(state_q) && !bus.rd_empty;
        bus.rd_en      = pop;
        bus.vram_req   = req_q;
        bus.vram_addr  = addr_q;
        bus.vram_wdata = wdata_q;
        busy           = (state_q != ST_IDLE);
        cmd_err        = err_q;
    end

endmodule
